// File: rtl/shift_issue.sv
`default_nettype none
// ============================================================================
// Module   : shift_issue
// Brief    : Two-stage issue/retire wrapper around an external RV32I barrel
//            shifter, with valid/ready handshake, backpressure and flush.
// Revision : 1.0 - initial release
// ============================================================================
module shift_issue #(
    parameter int DWIDTH      = 32,
    parameter int SHIFTDWIDTH = $clog2(DWIDTH),
    parameter int RD_W        = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    // issue side
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_funct3,
    input  logic                   in_funct7b5,
    input  logic                   in_is_imm,
    input  logic [DWIDTH-1:0]      in_rs1,
    input  logic [DWIDTH-1:0]      in_rs2,
    input  logic [SHIFTDWIDTH-1:0] in_imm_shamt,
    input  logic [RD_W-1:0]        in_rd,
    // external combinational shifter
    output logic [DWIDTH-1:0]      sh_din,
    output logic [SHIFTDWIDTH-1:0] sh_shamt,
    output logic                   sh_l_r,
    output logic                   sh_a_l,
    input  logic [DWIDTH-1:0]      sh_dout,
    // retire side
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      out_data,
    output logic [RD_W-1:0]        out_rd,
    output logic                   out_err
);

    localparam logic [2:0] C_F3_SLL = 3'b001;
    localparam logic [2:0] C_F3_SR  = 3'b101;

    // stage 1: decoded operands
    logic                   r_s1_valid;
    logic [DWIDTH-1:0]      r_s1_din;
    logic [SHIFTDWIDTH-1:0] r_s1_shamt;
    logic                   r_s1_l_r;
    logic                   r_s1_a_l;
    logic [RD_W-1:0]        r_s1_rd;
    logic                   r_s1_err;

    // stage 2: registered result
    logic                   r_s2_valid;
    logic [DWIDTH-1:0]      r_out_data;
    logic [RD_W-1:0]        r_out_rd;
    logic                   r_out_err;

    logic                   w_s2_free;
    logic                   w_s1_adv;
    logic                   w_accept;
    logic                   w_is_sll;
    logic                   w_is_sr;
    logic                   w_err;
    logic [SHIFTDWIDTH-1:0] w_shamt;
    logic                   w_unused;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;

    assign w_is_sll  = (in_funct3 == C_F3_SLL);
    assign w_is_sr   = (in_funct3 == C_F3_SR);
    assign w_err     = !((w_is_sll && !in_funct7b5) || w_is_sr);
    assign w_shamt   = in_is_imm ? in_imm_shamt : in_rs2[SHIFTDWIDTH-1:0];

    // Upper register-shamt bits carry no meaning for RV32I shifts.
    assign w_unused  = &{1'b0, in_rs2[DWIDTH-1:SHIFTDWIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_din   <= '0;
            r_s1_shamt <= '0;
            r_s1_l_r   <= 1'b0;
            r_s1_a_l   <= 1'b0;
            r_s1_rd    <= '0;
            r_s1_err   <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_din   <= in_rs1;
            r_s1_shamt <= w_shamt;
            r_s1_l_r   <= w_is_sll;
            r_s1_a_l   <= w_is_sr && in_funct7b5;
            r_s1_rd    <= in_rd;
            r_s1_err   <= w_err;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_rd   <= '0;
            r_out_err  <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            // Illegal ops still retire in order, but with a zeroed result.
            r_out_data <= r_s1_err ? '0 : sh_dout;
            r_out_rd   <= r_s1_rd;
            r_out_err  <= r_s1_err;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign sh_din    = r_s1_din;
    assign sh_shamt  = r_s1_shamt;
    assign sh_l_r    = r_s1_l_r;
    assign sh_a_l    = r_s1_a_l && !r_s1_l_r;

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_issue
// Brief    : Directed scoreboard bench for shift_issue with a reference
//            barrel shifter attached to the sh_* port group.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_issue;

    localparam int DWIDTH      = 32;
    localparam int SHIFTDWIDTH = 5;
    localparam int RD_W        = 5;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_funct3;
    logic                   in_funct7b5;
    logic                   in_is_imm;
    logic [DWIDTH-1:0]      in_rs1;
    logic [DWIDTH-1:0]      in_rs2;
    logic [SHIFTDWIDTH-1:0] in_imm_shamt;
    logic [RD_W-1:0]        in_rd;
    logic [DWIDTH-1:0]      sh_din;
    logic [SHIFTDWIDTH-1:0] sh_shamt;
    logic                   sh_l_r;
    logic                   sh_a_l;
    logic [DWIDTH-1:0]      sh_dout;
    logic                   out_valid;
    logic                   out_ready;
    logic [DWIDTH-1:0]      out_data;
    logic [RD_W-1:0]        out_rd;
    logic                   out_err;

    typedef struct {
        logic [DWIDTH-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    int                checks;
    int                errors;
    int                cyc;
    bit                last_acc;
    bit                lat_chk;
    logic [DWIDTH-1:0] last_data;
    logic              last_err;
    logic [DWIDTH-1:0] hold_data;

    shift_issue #(
        .DWIDTH      (DWIDTH),
        .SHIFTDWIDTH (SHIFTDWIDTH),
        .RD_W        (RD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct7b5  (in_funct7b5),
        .in_is_imm    (in_is_imm),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm_shamt (in_imm_shamt),
        .in_rd        (in_rd),
        .sh_din       (sh_din),
        .sh_shamt     (sh_shamt),
        .sh_l_r       (sh_l_r),
        .sh_a_l       (sh_a_l),
        .sh_dout      (sh_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shifter driven by the DUT's sh_* outputs.
    always_comb begin
        if (sh_l_r)      sh_dout = sh_din << sh_shamt;
        else if (sh_a_l) sh_dout = DWIDTH'($signed(sh_din) >>> sh_shamt);
        else             sh_dout = sh_din >> sh_shamt;
    end

    function automatic exp_t expect_op(input logic [2:0] f3, input logic f7,
                                       input logic imm_sel, input logic [DWIDTH-1:0] rs1,
                                       input logic [DWIDTH-1:0] rs2,
                                       input logic [SHIFTDWIDTH-1:0] imm,
                                       input logic [RD_W-1:0] rd);
        exp_t e;
        logic [SHIFTDWIDTH-1:0] sa;
        sa    = imm_sel ? imm : rs2[SHIFTDWIDTH-1:0];
        e.rd  = rd;
        e.cyc = 0;
        if (f3 == 3'b001 && !f7) begin
            e.data = rs1 << sa;
            e.err  = 1'b0;
        end else if (f3 == 3'b101) begin
            e.data = f7 ? DWIDTH'($signed(rs1) >>> sa) : rs1 >> sa;
            e.err  = 1'b0;
        end else begin
            e.data = '0;
            e.err  = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [DWIDTH-1:0] obs,
                       input logic [DWIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, score retire/accept, then advance.
    task automatic cycle();
        bit   acc;
        bit   ret;
        exp_t e;
        #3;
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (ret) begin
            chk("retire_expected", DWIDTH'(sb.size() != 0), DWIDTH'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_rd", DWIDTH'(out_rd), DWIDTH'(e.rd));
                chk("out_err", DWIDTH'(out_err), DWIDTH'(e.err));
                if (lat_chk) chk("latency", DWIDTH'(cyc), DWIDTH'(e.cyc));
            end
            last_data = out_data;
            last_err  = out_err;
        end
        if (rst || flush) begin
            sb.delete();
        end else if (acc) begin
            e = expect_op(in_funct3, in_funct7b5, in_is_imm, in_rs1, in_rs2,
                          in_imm_shamt, in_rd);
            e.cyc = cyc + 2;
            sb.push_back(e);
        end
        last_acc = acc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic f7, input logic imm_sel,
                         input logic [DWIDTH-1:0] rs1, input logic [DWIDTH-1:0] rs2,
                         input logic [SHIFTDWIDTH-1:0] imm, input logic [RD_W-1:0] rd);
        in_valid     = 1'b1;
        in_funct3    = f3;
        in_funct7b5  = f7;
        in_is_imm    = imm_sel;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_imm_shamt = imm;
        in_rd        = rd;
    endtask

    task automatic wait_accept(input string tag);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) break;
        end
        chk(tag, DWIDTH'(last_acc), DWIDTH'(1));
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] f3, input logic f7, input logic imm_sel,
                        input logic [DWIDTH-1:0] rs1, input logic [DWIDTH-1:0] rs2,
                        input logic [SHIFTDWIDTH-1:0] imm, input logic [RD_W-1:0] rd);
        drive(f3, f7, imm_sel, rs1, rs2, imm, rd);
        wait_accept("accept_timeout");
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat_chk = 1'b1;
        last_acc = 1'b0; last_data = '0; last_err = 1'b0; hold_data = '0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(3'b001, 1'b0, 1'b0, '0, '0, '0, '0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        cycle(); cycle();

        // reset state
        chk("rst_out_valid", DWIDTH'(out_valid), '0);
        chk("rst_in_ready", DWIDTH'(in_ready), DWIDTH'(1));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_rd", DWIDTH'(out_rd), '0);
        chk("rst_out_err", DWIDTH'(out_err), '0);
        chk("rst_sh_din", sh_din, '0);
        chk("rst_sh_ctl", DWIDTH'({sh_shamt, sh_l_r, sh_a_l}), '0);
        rst = 1'b0;
        cycle();

        // SLL by register, upper rs2 bits ignored
        send(3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFE4, 5'd0, 5'd3);
        idle(3);
        chk("t1_sll_data", last_data, 32'h0000_0010);
        chk("t1_sll_err", DWIDTH'(last_err), '0);

        // SRA / SRL immediate by 31
        send(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 5'd4);
        idle(3);
        chk("t2_sra_data", last_data, 32'hFFFF_FFFF);
        send(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 5'd5);
        idle(3);
        chk("t2_srl_data", last_data, 32'h0000_0001);

        // back-to-back, full throughput
        for (int i = 0; i < 8; i++) begin
            drive((i % 3 == 0) ? 3'b001 : 3'b101, (i % 3 == 2), i[0],
                  32'hF0F0_1234 ^ (32'h1111_1111 * i), 32'(i + 1), 5'(i * 3),
                  5'(i + 8));
            cycle();
            chk("b2b_accept", DWIDTH'(last_acc), DWIDTH'(1));
        end
        idle(3);
        chk("b2b_drained", DWIDTH'(sb.size()), '0);

        // backpressure: two ops fill the pipe, third is held off
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        send(3'b001, 1'b0, 1'b1, 32'h0000_00FF, 32'h0, 5'd8, 5'd20);
        send(3'b101, 1'b1, 1'b0, 32'hF000_0000, 32'h4, 5'd0, 5'd21);
        drive(3'b101, 1'b0, 1'b1, 32'h0000_FF00, 32'h0, 5'd4, 5'd22);
        chk("bp_in_ready_low", DWIDTH'(in_ready), '0);
        hold_data = out_data;
        chk("bp_hold_first", hold_data, 32'h0000_FF00);
        repeat (5) begin
            cycle();
            chk("bp_out_stable", out_data, hold_data);
            chk("bp_in_ready_stall", DWIDTH'(in_ready), '0);
            chk("bp_out_valid", DWIDTH'(out_valid), DWIDTH'(1));
        end
        out_ready = 1'b1;
        wait_accept("bp_accept_timeout");
        idle(4);
        chk("bp_drained", DWIDTH'(sb.size()), '0);
        lat_chk = 1'b1;

        // illegal funct3 then SLL by zero
        send(3'b000, 1'b0, 1'b0, 32'h1234_5678, 32'h3, 5'd0, 5'd9);
        idle(3);
        chk("t5_illegal_data", last_data, '0);
        chk("t5_illegal_err", DWIDTH'(last_err), DWIDTH'(1));
        send(3'b001, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 5'd2, 5'd10);
        idle(3);
        chk("t5_sll_f7_err", DWIDTH'(last_err), DWIDTH'(1));
        send(3'b001, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 5'd0, 5'd11);
        idle(3);
        chk("t5_sll0_data", last_data, 32'h1234_5678);
        chk("t5_sll0_err", DWIDTH'(last_err), '0);

        // random legal/illegal ops, full throughput
        for (int i = 0; i < 12; i++) begin
            drive(3'($urandom_range(7)), 1'($urandom), 1'($urandom), $urandom, $urandom,
                  5'($urandom), 5'(i));
            cycle();
        end
        idle(3);
        chk("rand_drained", DWIDTH'(sb.size()), '0);

        // flush with both stages full and an op offered
        out_ready = 1'b0;
        send(3'b001, 1'b0, 1'b1, 32'hAAAA_0001, 32'h0, 5'd1, 5'd1);
        send(3'b001, 1'b0, 1'b1, 32'hAAAA_0002, 32'h0, 5'd2, 5'd2);
        drive(3'b001, 1'b0, 1'b1, 32'hAAAA_0003, 32'h0, 5'd3, 5'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", DWIDTH'(out_valid), '0);
        chk("flush_in_ready", DWIDTH'(in_ready), DWIDTH'(1));
        out_ready = 1'b1;
        idle(3);
        chk("flush_quiet", DWIDTH'(out_valid), '0);

        // reset mid-stream
        out_ready = 1'b0;
        send(3'b101, 1'b1, 1'b1, 32'h8888_0000, 32'h0, 5'd4, 5'd6);
        send(3'b101, 1'b0, 1'b1, 32'h8888_0000, 32'h0, 5'd4, 5'd7);
        drive(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd5, 5'd8);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst2_out_valid", DWIDTH'(out_valid), '0);
        chk("rst2_out_data", out_data, '0);
        chk("rst2_out_rd", DWIDTH'(out_rd), '0);
        chk("rst2_sh_din", sh_din, '0);
        out_ready = 1'b1;
        idle(3);
        chk("rst2_quiet", DWIDTH'(out_valid), '0);

        // pipeline still works after reset
        send(3'b101, 1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FF20, 5'd0, 5'd31);
        idle(3);
        chk("post_rst_sra0", last_data, 32'h8000_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
